// File: rtl/timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : timing_gen
// Description : Beat and machine-cycle generator for the hardwired controller.
//               Produces machine-cycle levels w1/w2/w3 and beat pulses
//               t1..t4. The controller's short/long/stop outputs, sampled on
//               the edge that ends T4, shorten, extend or halt execution.
//               Execution starts on a 0->1 transition of the start button qd.
// Ports       : clk      - system clock, rising edge
//               clr      - synchronous active-high reset
//               qd       - start button (level, rising transition starts)
//               short    - current W1 is the last machine cycle
//               long     - insert W3 after W2
//               stop     - halt at end of current machine cycle
//               w1..w3   - machine cycle levels (one-hot while running)
//               t1..t4   - beat pulses (one-hot while running)
//               running  - high while cycles are being generated
//               cyc_cnt  - completed machine cycles since reset, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module timing_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             qd,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             t4,
    output logic             running,
    output logic [CNT_W-1:0] cyc_cnt
);

    // Top-level run state
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Machine-cycle state
    localparam logic [1:0] c_W_1 = 2'd0;
    localparam logic [1:0] c_W_2 = 2'd1;
    localparam logic [1:0] c_W_3 = 2'd2;

    // Beat within a machine cycle
    localparam logic [1:0] c_T_1 = 2'd0;
    localparam logic [1:0] c_T_4 = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [0:0]       r_state;
    logic [1:0]       r_wst;
    logic [1:0]       r_beat;
    logic             r_qd_hist;
    logic [CNT_W-1:0] r_cnt;
    logic             r_w1, r_w2, r_w3;
    logic             r_t1, r_t2, r_t3, r_t4;
    logic             r_running;

    logic [0:0]       w_nxt_state;
    logic [1:0]       w_nxt_wst;
    logic [1:0]       w_nxt_beat;
    logic             w_cnt_inc;
    logic             w_start;
    logic             w_nxt_run;

    // Start edge: qd high now, low on the previous clock. The history register
    // is forced to 1 by reset so a button held through reset cannot start.
    assign w_start = qd & ~r_qd_hist;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_wst   = r_wst;
        w_nxt_beat  = r_beat;
        w_cnt_inc   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_nxt_state = c_ST_RUN;
                    w_nxt_wst   = c_W_1;
                    w_nxt_beat  = c_T_1;
                end
            end

            c_ST_RUN: begin
                if (r_beat != c_T_4) begin
                    w_nxt_beat = r_beat + 2'd1;
                end else begin
                    // End of machine cycle: the only point where the
                    // controller's short/long/stop are honoured.
                    w_cnt_inc  = 1'b1;
                    w_nxt_beat = c_T_1;
                    if (stop) begin
                        w_nxt_state = c_ST_IDLE;
                        w_nxt_wst   = c_W_1;
                    end else begin
                        case (r_wst)
                            c_W_1:   w_nxt_wst = short ? c_W_1 : c_W_2;
                            c_W_2:   w_nxt_wst = long  ? c_W_3 : c_W_1;
                            default: w_nxt_wst = c_W_1;
                        endcase
                    end
                end
            end

            default: begin
                w_nxt_state = c_ST_IDLE;
                w_nxt_wst   = c_W_1;
                w_nxt_beat  = c_T_1;
            end
        endcase
    end

    assign w_nxt_run = (w_nxt_state == c_ST_RUN);

    // ------------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state so
    // they line up with the state they describe without a combinational path.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= c_ST_IDLE;
            r_wst     <= c_W_1;
            r_beat    <= c_T_1;
            r_qd_hist <= 1'b1;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_w1      <= 1'b0;
            r_w2      <= 1'b0;
            r_w3      <= 1'b0;
            r_t1      <= 1'b0;
            r_t2      <= 1'b0;
            r_t3      <= 1'b0;
            r_t4      <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_wst     <= w_nxt_wst;
            r_beat    <= w_nxt_beat;
            r_qd_hist <= qd;
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            r_running <= w_nxt_run;
            r_w1      <= w_nxt_run && (w_nxt_wst  == c_W_1);
            r_w2      <= w_nxt_run && (w_nxt_wst  == c_W_2);
            r_w3      <= w_nxt_run && (w_nxt_wst  == c_W_3);
            r_t1      <= w_nxt_run && (w_nxt_beat == 2'd0);
            r_t2      <= w_nxt_run && (w_nxt_beat == 2'd1);
            r_t3      <= w_nxt_run && (w_nxt_beat == 2'd2);
            r_t4      <= w_nxt_run && (w_nxt_beat == 2'd3);
        end
    end

    assign w1      = r_w1;
    assign w2      = r_w2;
    assign w3      = r_w3;
    assign t1      = r_t1;
    assign t2      = r_t2;
    assign t3      = r_t3;
    assign t4      = r_t4;
    assign running = r_running;
    assign cyc_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_timing_gen
// Description : Self-checking bench for timing_gen. A behavioural model
//               (beat/cycle numbers as plain integers) predicts the outputs
//               after every clock edge; predictions are queued and a monitor
//               compares them against the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timing_gen;

    localparam int CNT_W = 4;
    localparam int VW    = CNT_W + 8;

    logic             clk = 1'b0;
    logic             clr, qd, short, long, stop;
    logic             w1, w2, w3, t1, t2, t3, t4, running;
    logic [CNT_W-1:0] cyc_cnt;

    timing_gen #(.CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .clr     (clr),
        .qd      (qd),
        .short   (short),
        .long    (long),
        .stop    (stop),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
        .t1      (t1),
        .t2      (t2),
        .t3      (t3),
        .t4      (t4),
        .running (running),
        .cyc_cnt (cyc_cnt)
    );

    always #5 clk = ~clk;

    // Model state: machine cycle number 1..3, beat number 1..4
    bit m_run;
    int m_w;
    int m_t;
    int m_cnt;
    bit m_qdh;

    logic [VW-1:0] exp_q[$];
    int n_tests  = 0;
    int n_failed = 0;
    bit done     = 1'b0;

    function automatic logic [VW-1:0] pack_exp();
        logic [VW-1:0] v;
        v = {m_run,
             m_run && (m_w == 1), m_run && (m_w == 2), m_run && (m_w == 3),
             m_run && (m_t == 1), m_run && (m_t == 2),
             m_run && (m_t == 3), m_run && (m_t == 4),
             CNT_W'(m_cnt)};
        return v;
    endfunction

    // Apply inputs for one clock edge and advance the model by that edge.
    task automatic step(input bit c, input bit q, input bit s, input bit l, input bit p);
        clr = c; qd = q; short = s; long = l; stop = p;
        if (c) begin
            m_run = 0; m_w = 1; m_t = 1; m_cnt = 0; m_qdh = 1;
        end else begin
            if (!m_run) begin
                if (q && !m_qdh) begin
                    m_run = 1; m_w = 1; m_t = 1;
                end
            end else if (m_t < 4) begin
                m_t = m_t + 1;
            end else begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_t   = 1;
                if (p) begin
                    m_run = 0; m_w = 1;
                end else if (m_w == 1) begin
                    m_w = s ? 1 : 2;
                end else if (m_w == 2) begin
                    m_w = l ? 3 : 1;
                end else begin
                    m_w = 1;
                end
            end
            m_qdh = q;
        end
        @(posedge clk);
        exp_q.push_back(pack_exp());
        #1;
    endtask

    // Monitor: compare every predicted output against the DUT mid-cycle.
    initial begin
        logic [VW-1:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {running, w1, w2, w3, t1, t2, t3, t4, cyc_cnt};
                n_tests++;
                if (a !== e) begin
                    n_failed++;
                    $display("FAIL outputs @%0t: got run=%b w=%b%b%b t=%b%b%b%b cnt=%0d, expected run=%b w=%b%b%b t=%b%b%b%b cnt=%0d",
                             $time, a[VW-1], a[VW-2], a[VW-3], a[VW-4], a[VW-5], a[VW-6], a[VW-7], a[VW-8], a[CNT_W-1:0],
                             e[VW-1], e[VW-2], e[VW-3], e[VW-4], e[VW-5], e[VW-6], e[VW-7], e[VW-8], e[CNT_W-1:0]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete, expected finish");
            $fatal(1, "timeout");
        end
    end

    initial begin
        bit rq;
        clr = 1; qd = 0; short = 0; long = 0; stop = 0;
        m_run = 0; m_w = 1; m_t = 1; m_cnt = 0; m_qdh = 1;
        @(posedge clk); #1;

        // Reset two clocks, then a 3-clock qd pulse
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);

        // short=1: stay in W1 for several machine cycles
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);

        // W1/W2 alternation, then long during W2 to insert W3
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, m_w == 2, 0);

        // stop only in W2 T2 is ignored; stop in W2 T4 halts
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, m_run && m_w == 2 && m_t == 2);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, m_w == 2 && m_t == 4);
        for (int i = 0; i < 4; i++)  step(0, 1, 0, 0, 0);   // qd held: no restart
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0);   // fresh edge restarts

        // clr mid-cycle in W3 T2 with qd already high
        for (int i = 0; i < 16 && !(m_w == 3 && m_t == 2); i++) step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);

        // Counter wrap: 17+ machine cycles at CNT_W=4
        for (int i = 0; i < 72; i++) step(0, 0, 1, 0, 0);

        // Randomised traffic
        rq = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rq = ~rq;
            step($urandom_range(0, 149) == 0, rq, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 11) == 0);
        end

        @(negedge clk); #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_failed++;
            $display("FAIL drain: %0d predictions unchecked, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timing_gen.md
Name: timing_gen

Overview:
Beat and machine-cycle generator that sits directly upstream of the hardwired controller. It produces the machine-cycle signals w1/w2/w3 and the beat pulses t1..t4 that the controller decodes, including t3, which clocks the controller's st0 flag. It consumes the controller's short, long and stop outputs to shorten, extend or halt instruction execution. It also starts execution on the operator start button qd.

Parameters:
CNT_W, 16, width of the machine-cycle counter cyc_cnt.

Ports:
clk  input  1  system clock; all state changes on rising edge
clr  input  1  reset, synchronous, active-high
qd  input  1  start button, level; a 0->1 transition starts the machine
short  input  1  from controller: current W1 is the last machine cycle
long  input  1  from controller: add W3 after W2
stop  input  1  from controller: halt at end of current machine cycle
w1  output  1  machine cycle 1 active
w2  output  1  machine cycle 2 active
w3  output  1  machine cycle 3 active
t1  output  1  beat 1 of current machine cycle
t2  output  1  beat 2
t3  output  1  beat 3; controller st0 update beat
t4  output  1  beat 4; short/long/stop sample beat
running  output  1  1 while generating cycles
cyc_cnt  output  CNT_W  completed machine cycles since reset, wraps

Behaviour:
- Reset:
  - Clock edge with clr=1 forces: state IDLE, W state=W1, beat=T1, running=0, w1..w3=0, t1..t4=0, cyc_cnt=0.
  - qd history register set to 1, so a qd held high through reset does not start the machine.
  - clr has priority over every other input and applies in any state, including mid-cycle.
- All outputs are registered and there are no combinational input-to-output paths.
- IDLE:
  - All w* and t* outputs are 0; running=0.
  - Start edge = qd=1 and the qd history register=0, sampled on the same edge.
  - On a start edge, the next state is RUN with W1 and T1, so w1=1, t1=1 and running=1 in the cycle after the edge.
- RUN:
  - Exactly one of t1..t4 is high; the beat advances T1->T2->T3->T4->T1 every clock.
  - Exactly one of w1..w3 is high and is constant across all four beats of a machine cycle.
  - qd is ignored, though its history register still updates every clock.
- End-of-cycle decision, made on the clock edge that ends T4 (short/long/stop sampled there only; their values in T1..T3 are ignored):
  - stop=1 (highest priority): go to IDLE; W state resets to W1 for the next start; running=0 and all w*/t* outputs are 0 the next cycle.
  - Otherwise, from W1: short=1 goes to W1, short=0 goes to W2; long is ignored.
  - From W2: long=1 goes to W3, long=0 goes to W1; short is ignored.
  - From W3: always goes to W1; short and long are ignored.
- cyc_cnt:
  - Increments by 1 on every T4-ending edge in RUN, including the one that takes stop.
  - Wraps from 2^CNT_W-1 to 0.
  - Held in IDLE.
- Simultaneous events:
  - clr with anything: reset wins.
  - stop with short/long: stop wins.
  - qd edge in the same clock as a stop-induced halt: ignored, because the machine is RUN on that edge; a fresh 0->1 is required.
- Restart after stop resumes at W1/T1; the controller is responsible for the PC/IR context.

Test Plan:
1. Assert clr for 2 clocks, release, pulse qd high for 3 clocks -> one cycle after the first qd=1 edge, w1=1 and t1=1; t sequence is t1,t2,t3,t4,t1 on consecutive clocks; running=1.
2. Hold short=1, long=0, stop=0 for 5 machine cycles -> w1 stays 1 for 20 clocks, w2/w3 never high; cyc_cnt=5.
3. short=0, long=0 -> pattern W1,W2,W1,W2 each 4 clocks; then long=1 during W2 T4 -> W3 for 4 clocks, then W1; cyc_cnt increments once per 4 clocks.
4. stop=1 asserted only in W2 T2 then dropped -> no halt. stop=1 in W2 T4 -> next cycle running=0 and all w/t=0; cyc_cnt frozen. qd held high -> no restart; qd 0 then 1 -> restart at w1/t1.
5. clr=1 during W3 T2 -> next cycle IDLE, all outputs 0, cyc_cnt=0. qd already high during clr -> no start until qd drops and rises.
6. CNT_W=4, run 17 machine cycles -> cyc_cnt goes 15 -> 0 -> 1.
